onchip_stream_writer: RTL and testbench

Byte-stream-to-memory packer that sits directly upstream of the 1024×32 single-port on-chip RAM and drives its Avalon-MM slave write port. It accepts an 8-bit valid/ready stream and packs bytes little-endian into 32-bit words. Each completed or terminated word is written at an incrementing word address starting from a software-supplied base. A start/busy/done control interface frames one transfer, ending on end-of-packet.

---
 rtl/onchip_stream_writer.sv | 164 ++++++++++++++++
 tb/tb_onchip_stream_writer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_stream_writer.sv
// rtl/onchip_stream_writer.sv - byte stream to 32-bit little-endian word packer driving an Avalon-MM RAM write port
// Optional running byte checksum enabled by defining ONCHIP_STREAM_WRITER_CHECKSUM_EN.
module onchip_stream_writer #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  words_written,
  output logic [15:0]       checksum,
  input  logic [7:0]        snk_data,
  input  logic              snk_valid,
  input  logic              snk_eop,
  output logic              snk_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken
);

  typedef enum logic [1:0] {S_IDLE, S_PACK, S_WRITE, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [1:0]        r_lane;
  logic [3:0]        r_be;
  logic [31:0]       r_data;
  logic              r_last;
  logic [CNT_W-1:0]  r_words;

  logic              w_accept;
  logic [31:0]       w_data;
  logic [3:0]        w_be;
  logic              w_busy;
  logic              w_ready;
  logic              w_wr;
  logic              w_done;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_be_out;
  logic [31:0]       w_wdata;

  assign w_accept      = (r_state == S_PACK) && snk_valid;
  assign words_written = r_words;

  // Lanes are cleared after each write, so OR-ing the new byte in is sufficient.
  always_comb begin
    w_data = r_data;
    w_be   = r_be;
    if (w_accept) begin
      w_data = r_data | (32'(snk_data) << {r_lane, 3'b000});
      w_be   = r_be | (4'b0001 << r_lane);
    end
  end

  // State register plus the registered outputs, all decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      snk_ready      <= 1'b0;
      mem_address    <= '0;
      mem_byteenable <= 4'b0000;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= 32'd0;
      mem_clken      <= 1'b1;
    end else begin
      r_state        <= w_next;
      busy           <= w_busy;
      done           <= w_done;
      snk_ready      <= w_ready;
      mem_address    <= w_addr;
      mem_byteenable <= w_be_out;
      mem_chipselect <= w_wr;
      mem_write      <= w_wr;
      mem_writedata  <= w_wdata;
      mem_clken      <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_PACK;
      S_PACK:  if (w_accept && ((r_lane == 2'd3) || snk_eop)) w_next = S_WRITE;
      S_WRITE: w_next = r_last ? S_DONE : S_PACK;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (w_next != S_IDLE);
    w_ready  = (w_next == S_PACK);
    w_wr     = (w_next == S_WRITE);
    w_done   = (w_next == S_DONE);
    w_addr   = w_wr ? r_ptr : '0;
    w_be_out = w_wr ? w_be : 4'b0000;
    w_wdata  = w_wr ? w_data : 32'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr   <= '0;
      r_lane  <= 2'd0;
      r_be    <= 4'b0000;
      r_data  <= 32'd0;
      r_last  <= 1'b0;
      r_words <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_ptr   <= base_addr;
          r_lane  <= 2'd0;
          r_be    <= 4'b0000;
          r_data  <= 32'd0;
          r_last  <= 1'b0;
          r_words <= '0;
        end
        S_PACK: if (w_accept) begin
          r_data <= w_data;
          r_be   <= w_be;
          r_lane <= r_lane + 2'd1;
          r_last <= snk_eop;
        end
        S_WRITE: begin
          r_ptr   <= r_ptr + ADDR_W'(1);
          r_words <= r_words + CNT_W'(1);
          r_lane  <= 2'd0;
          r_be    <= 4'b0000;
          r_data  <= 32'd0;
        end
        default: ;
      endcase
    end
  end

`ifdef ONCHIP_STREAM_WRITER_CHECKSUM_EN
  logic [15:0] r_sum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum <= 16'd0;
    end else if ((r_state == S_IDLE) && start) begin
      r_sum <= 16'd0;
    end else if (w_accept) begin
      r_sum <= r_sum + 16'(snk_data);
    end
  end

  assign checksum = r_sum;
`else
  assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_onchip_stream_writer.sv
// tb/tb_onchip_stream_writer.sv - directed self-checking bench for onchip_stream_writer
module tb_onchip_stream_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = 10'd0;
  logic        busy, done;
  logic [10:0] words_written;
  logic [15:0] checksum;
  logic [7:0]  snk_data = 8'd0;
  logic        snk_valid = 1'b0;
  logic        snk_eop = 1'b0;
  logic        snk_ready;
  logic [9:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;

  onchip_stream_writer #(.ADDR_W(10), .CNT_W(11)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .words_written(words_written), .checksum(checksum),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_eop(snk_eop), .snk_ready(snk_ready),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [9:0]  q_addr[$];
  logic [3:0]  q_be[$];
  logic [31:0] q_data[$];
  int          q_cyc[$];
  logic [7:0]  tb_bytes[0:15];
  logic [7:0]  lfsr = 8'hA5;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_sum(input logic [15:0] s);
`ifdef ONCHIP_STREAM_WRITER_CHECKSUM_EN
    return {16'd0, s};
`else
    return 32'd0 & {16'd0, s};
`endif
  endfunction

  always @(negedge clk) begin
    if (reset_n && mem_write) begin
      q_addr.push_back(mem_address);
      q_be.push_back(mem_byteenable);
      q_data.push_back(mem_writedata);
      q_cyc.push_back(cyc);
      check_eq("cs_with_write", {31'd0, mem_chipselect}, 32'd1);
      check_eq("be_nonzero", {31'd0, mem_byteenable != 4'b0000}, 32'd1);
    end
    if (reset_n && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic clear_obs();
    q_addr.delete(); q_be.delete(); q_data.delete(); q_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic check_wr(input int k, input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
    if (q_addr.size() > k) begin
      check_eq($sformatf("wr%0d_addr", k), {22'd0, q_addr[k]}, {22'd0, a});
      check_eq($sformatf("wr%0d_be", k), {28'd0, q_be[k]}, {28'd0, be});
      check_eq($sformatf("wr%0d_data", k), q_data[k], d);
    end else begin
      check_eq($sformatf("wr%0d_present", k), q_addr.size(), k + 1);
    end
  endtask

  task automatic run_xfer(input logic [9:0] base, input int n, input bit stall, input bit mid_start);
    int idx = 0;
    int guard = 0;
    bit go;
    bit accepted;
    @(negedge clk);
    start = 1'b1; base_addr = base; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0; base_addr = base ^ 10'h155;
    check_eq("busy_after_start", {31'd0, busy}, 32'd1);
    check_eq("ready_after_start", {31'd0, snk_ready}, 32'd1);
    while (idx < n && guard < 2000) begin
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      go = stall ? lfsr[0] : 1'b1;
      snk_valid = go;
      snk_data  = tb_bytes[idx];
      snk_eop   = (idx == n - 1);
      start     = mid_start && (idx == 2);
      accepted  = go && snk_ready;
      @(negedge clk);
      if (accepted) idx++;
      guard++;
    end
    snk_valid = 1'b0; snk_eop = 1'b0; start = 1'b0;
    check_eq("bytes_sent", idx, n);
    guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_eq("busy_cleared", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_ready", {31'd0, snk_ready}, 32'd0);
    check_eq("rst_write", {31'd0, mem_write}, 32'd0);
    check_eq("rst_clken", {31'd0, mem_clken}, 32'd1);
    check_eq("rst_ww", {21'd0, words_written}, 32'd0);
    check_eq("rst_csum", {16'd0, checksum}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 8 bytes 0x01..0x08 at base 0x010
    for (int i = 0; i < 8; i++) tb_bytes[i] = 8'(i + 1);
    clear_obs();
    run_xfer(10'h010, 8, 1'b0, 1'b0);
    check_eq("t1_nwr", q_addr.size(), 2);
    check_wr(0, 10'h010, 4'b1111, 32'h04030201);
    check_wr(1, 10'h011, 4'b1111, 32'h08070605);
    check_eq("t1_ww", {21'd0, words_written}, 32'd2);
    check_eq("t1_done", done_cnt, 1);
    check_eq("t1_csum", {16'd0, checksum}, exp_sum(16'h0024));
    if (q_cyc.size() == 2) begin
      check_eq("t1_first_wr_lat", q_cyc[0] - start_cyc, 5);
      check_eq("t1_done_lat", done_cyc - q_cyc[1], 1);
    end

    // 5 bytes, partial last word
    tb_bytes[0] = 8'hAA; tb_bytes[1] = 8'hBB; tb_bytes[2] = 8'hCC;
    tb_bytes[3] = 8'hDD; tb_bytes[4] = 8'hEE;
    clear_obs();
    run_xfer(10'h000, 5, 1'b0, 1'b0);
    check_eq("t2_nwr", q_addr.size(), 2);
    check_wr(0, 10'h000, 4'b1111, 32'hDDCCBBAA);
    check_wr(1, 10'h001, 4'b0001, 32'h000000EE);
    check_eq("t2_csum", {16'd0, checksum}, exp_sum(16'h03FC));

    // single byte at top address
    tb_bytes[0] = 8'h5A;
    clear_obs();
    run_xfer(10'h3FF, 1, 1'b0, 1'b0);
    check_eq("t3_nwr", q_addr.size(), 1);
    check_wr(0, 10'h3FF, 4'b0001, 32'h0000005A);
    check_eq("t3_ww", {21'd0, words_written}, 32'd1);
    check_eq("t3_done", done_cnt, 1);

    // 12 bytes with address wrap, eop on a lane-3 byte
    for (int i = 0; i < 12; i++) tb_bytes[i] = 8'(i + 1);
    clear_obs();
    run_xfer(10'h3FF, 12, 1'b0, 1'b0);
    check_eq("t4_nwr", q_addr.size(), 3);
    check_wr(0, 10'h3FF, 4'b1111, 32'h04030201);
    check_wr(1, 10'h000, 4'b1111, 32'h08070605);
    check_wr(2, 10'h001, 4'b1111, 32'h0C0B0A09);
    check_eq("t4_ww", {21'd0, words_written}, 32'd3);
    check_eq("t4_csum", {16'd0, checksum}, exp_sum(16'h004E));

    // stalled stream with an ignored start mid-transfer
    for (int i = 0; i < 7; i++) tb_bytes[i] = 8'(8'h31 + i);
    clear_obs();
    run_xfer(10'h100, 7, 1'b1, 1'b1);
    check_eq("t5_nwr", q_addr.size(), 2);
    check_wr(0, 10'h100, 4'b1111, 32'h34333231);
    check_wr(1, 10'h101, 4'b0111, 32'h00373635);
    check_eq("t5_ww", {21'd0, words_written}, 32'd2);
    check_eq("t5_done", done_cnt, 1);
    check_eq("t5_csum", {16'd0, checksum}, exp_sum(16'h016C));
    repeat (3) @(negedge clk);
    check_eq("t5_no_restart", {31'd0, busy}, 32'd0);

    // reset asserted while the write strobe is up
    @(negedge clk);
    start = 1'b1; base_addr = 10'h050;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      snk_valid = 1'b1; snk_data = 8'(8'hC0 + i); snk_eop = 1'b0;
      @(negedge clk);
    end
    snk_valid = 1'b0;
    check_eq("t6_write_up", {31'd0, mem_write}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("t6_rst_write", {31'd0, mem_write}, 32'd0);
    check_eq("t6_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("t6_rst_ready", {31'd0, snk_ready}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tb_bytes[0] = 8'h11; tb_bytes[1] = 8'h22;
    clear_obs();
    run_xfer(10'h020, 2, 1'b0, 1'b0);
    check_eq("t6_nwr", q_addr.size(), 1);
    check_wr(0, 10'h020, 4'b0011, 32'h00002211);
    check_eq("t6_ww", {21'd0, words_written}, 32'd1);
    check_eq("t6_csum", {16'd0, checksum}, exp_sum(16'h0033));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
